// File: rtl/dm_cache_ctrl_param.sv
// Direct-mapped, write-back, write-allocate cache controller with internal
// tag/data arrays, a line-wide memory port and a whole-cache flush.
// Outputs are decoded from the state register so that a hit completes in the
// cycle right after the request is accepted.
module dm_cache_ctrl_param #(
  parameter int ADDR_W           = 20,
  parameter int CPU_W            = 32,
  parameter int LINE_W           = 128,
  parameter int INDEX_W          = 10,
  parameter int FLUSH_INVALIDATE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_valid,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [CPU_W-1:0]  cpu_wdata,
  output logic [CPU_W-1:0]  cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_stopped,
  input  logic              flush_req,
  output logic              flush_done,
  output logic              mem_valid,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);
  localparam int NUM_LINES = 2 ** INDEX_W;
  localparam int OFFSET_W  = $clog2(LINE_W / 8);
  localparam int TAG_W     = ADDR_W - INDEX_W - OFFSET_W;
  localparam int WSEL_W    = $clog2(LINE_W / CPU_W);
  localparam int BYTE_W    = $clog2(CPU_W / 8);
  localparam logic [OFFSET_W-1:0] ZERO_OFF = '0;
  localparam logic [INDEX_W:0]    SCAN_ONE = {{INDEX_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE, S_COMPARE, S_WRITE_BACK, S_ALLOCATE, S_FLUSH_SCAN, S_FLUSH_WB
  } state_t;

  state_t state, next_state;

  logic [LINE_W-1:0]    data_mem [NUM_LINES];
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_bits, dirty_bits;

  logic              req_rw;
  logic [ADDR_W-1:0] req_addr;
  logic [CPU_W-1:0]  req_wdata;
  logic              retry;
  logic [INDEX_W:0]  scan_idx;

  logic [TAG_W-1:0]   req_tag, cur_tag;
  logic [INDEX_W-1:0] req_idx, scan_line, line_idx;
  logic [WSEL_W-1:0]  req_wsel;
  logic [LINE_W-1:0]  cur_line;
  logic               cur_valid, cur_dirty, hit;
  logic               accept, scan_start, scan_inc;
  logic               do_hit_wr, do_fill, do_clean, do_inval;
  logic               unused_byte_bits;

  assign req_tag   = req_addr[ADDR_W-1 -: TAG_W];
  assign req_idx   = req_addr[OFFSET_W +: INDEX_W];
  assign req_wsel  = req_addr[OFFSET_W-1 -: WSEL_W];
  assign scan_line = scan_idx[INDEX_W-1:0];
  // Byte-within-word bits never select anything: word-granular access only.
  assign unused_byte_bits = ^req_addr[BYTE_W-1:0];

  // The flush walks its own index; everything else looks at the request index.
  assign line_idx  = (state == S_FLUSH_SCAN || state == S_FLUSH_WB) ? scan_line : req_idx;
  assign cur_line  = data_mem[line_idx];
  assign cur_tag   = tag_mem[line_idx];
  assign cur_valid = valid_bits[line_idx];
  assign cur_dirty = dirty_bits[line_idx];
  assign hit       = cur_valid && (cur_tag == req_tag);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state decode, port outputs and array update strobes
  always_comb begin
    next_state  = state;
    cpu_ready   = 1'b0;
    cpu_rdata   = '0;
    cpu_stopped = 1'b0;
    flush_done  = 1'b0;
    mem_valid   = 1'b0;
    mem_rw      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    accept      = 1'b0;
    scan_start  = 1'b0;
    scan_inc    = 1'b0;
    do_hit_wr   = 1'b0;
    do_fill     = 1'b0;
    do_clean    = 1'b0;
    do_inval    = 1'b0;
    case (state)
      S_IDLE: begin
        if (flush_req) begin
          scan_start = 1'b1;
          next_state = S_FLUSH_SCAN;
        end else if (cpu_valid) begin
          accept     = 1'b1;
          next_state = S_COMPARE;
        end else begin
          next_state = S_IDLE;
        end
      end
      S_COMPARE: begin
        cpu_stopped = retry;
        if (hit) begin
          cpu_ready  = 1'b1;
          next_state = S_IDLE;
          if (req_rw) do_hit_wr = 1'b1;
          else        cpu_rdata = cur_line[req_wsel*CPU_W +: CPU_W];
        end else if (cur_valid && cur_dirty) begin
          next_state = S_WRITE_BACK;
        end else begin
          next_state = S_ALLOCATE;
        end
      end
      S_WRITE_BACK: begin
        cpu_stopped = 1'b1;
        mem_valid   = 1'b1;
        mem_rw      = 1'b1;
        mem_addr    = {cur_tag, req_idx, ZERO_OFF};
        mem_wdata   = cur_line;
        if (mem_ready) next_state = S_ALLOCATE;
        else           next_state = S_WRITE_BACK;
      end
      S_ALLOCATE: begin
        cpu_stopped = 1'b1;
        mem_valid   = 1'b1;
        mem_addr    = {req_tag, req_idx, ZERO_OFF};
        if (mem_ready) begin
          do_fill    = 1'b1;
          next_state = S_COMPARE;
        end else begin
          next_state = S_ALLOCATE;
        end
      end
      S_FLUSH_SCAN: begin
        cpu_stopped = 1'b1;
        if (scan_idx[INDEX_W]) begin
          flush_done = 1'b1;
          next_state = S_IDLE;
        end else if (cur_valid && cur_dirty) begin
          next_state = S_FLUSH_WB;
        end else begin
          do_inval = (FLUSH_INVALIDATE != 0);
          scan_inc = 1'b1;
        end
      end
      S_FLUSH_WB: begin
        cpu_stopped = 1'b1;
        mem_valid   = 1'b1;
        mem_rw      = 1'b1;
        mem_addr    = {cur_tag, scan_line, ZERO_OFF};
        mem_wdata   = cur_line;
        if (mem_ready) begin
          do_clean   = 1'b1;
          do_inval   = (FLUSH_INVALIDATE != 0);
          scan_inc   = 1'b1;
          next_state = S_FLUSH_SCAN;
        end else begin
          next_state = S_FLUSH_WB;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Request latch, post-allocate marker and flush index counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_rw    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      retry     <= 1'b0;
      scan_idx  <= '0;
    end else begin
      if (accept) begin
        req_rw    <= cpu_rw;
        req_addr  <= cpu_addr;
        req_wdata <= cpu_wdata;
      end
      retry <= do_fill;
      if (scan_start)    scan_idx <= '0;
      else if (scan_inc) scan_idx <= scan_idx + SCAN_ONE;
    end
  end

  // Valid/dirty bookkeeping; these are the only bits cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_bits <= '0;
      dirty_bits <= '0;
    end else begin
      if (do_fill) begin
        valid_bits[req_idx] <= 1'b1;
        dirty_bits[req_idx] <= 1'b0;
      end else if (do_hit_wr) begin
        dirty_bits[req_idx] <= 1'b1;
      end
      if (do_clean) dirty_bits[scan_line] <= 1'b0;
      if (do_inval) valid_bits[scan_line] <= 1'b0;
    end
  end

  // Line and tag storage: filled on allocate, one word patched on a write hit
  always_ff @(posedge clk) begin
    if (do_fill) begin
      data_mem[req_idx] <= mem_rdata;
      tag_mem[req_idx]  <= req_tag;
    end else if (do_hit_wr) begin
      data_mem[req_idx][req_wsel*CPU_W +: CPU_W] <= req_wdata;
    end
  end
endmodule

// File: tb/tb_dm_cache_ctrl_param.sv
// Directed bench for dm_cache_ctrl_param (default geometry): a reference cache
// model plus a fixed-latency memory responder that checks every bus cycle.
module tb_dm_cache_ctrl_param;
  localparam int LMEM = 3;
  localparam int NL   = 1024;
  localparam int FI   = 0;

  logic         clk = 1'b0, rst = 1'b1;
  logic         cpu_valid = 1'b0, cpu_rw = 1'b0, flush_req = 1'b0;
  logic [19:0]  cpu_addr = 20'h0;
  logic [31:0]  cpu_wdata = 32'h0;
  logic [31:0]  cpu_rdata;
  logic         cpu_ready, cpu_stopped, flush_done, mem_valid, mem_rw;
  logic [19:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = 128'h0;
  logic         mem_ready = 1'b0;

  dm_cache_ctrl_param #(.ADDR_W(20), .CPU_W(32), .LINE_W(128), .INDEX_W(10),
                        .FLUSH_INVALIDATE(FI)) dut (
    .clk(clk), .rst(rst), .cpu_valid(cpu_valid), .cpu_rw(cpu_rw),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready), .cpu_stopped(cpu_stopped), .flush_req(flush_req),
    .flush_done(flush_done), .mem_valid(mem_valid), .mem_rw(mem_rw),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready));

  always #5 clk = ~clk;

  typedef struct packed { logic rw; logic [19:0] addr; logic [127:0] data; } txn_t;
  txn_t         exp_q[$];
  logic [127:0] mem_store [logic [19:0]];

  bit           m_valid [NL];
  bit           m_dirty [NL];
  logic [5:0]   m_tag   [NL];
  logic [127:0] m_line  [NL];

  int total = 0, bad = 0;
  int ready_cnt = 0, wr_cnt = 0, txn_cnt = 0, wait_cnt = 0;
  bit mem_stall = 1'b0;
  logic         last_rw = 1'b0;
  logic [19:0]  last_addr = 20'h0, lw_addr = 20'h0;
  logic [127:0] lw_data = 128'h0;

  // Untouched memory line: word k = {5A, k, line byte address}.
  function automatic logic [127:0] mem_read(input logic [19:0] a);
    logic [127:0] r;
    if (mem_store.exists(a)) return mem_store[a];
    for (int k = 0; k < 4; k++) r[k*32 +: 32] = {8'h5A, 4'(k), a};
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory side: check each bus cycle against the expected transaction list and answer after LMEM cycles.
  always @(negedge clk) begin
    if (rst) begin
      mem_ready = 1'b0;
      wait_cnt  = 0;
    end else begin
      if (cpu_ready === 1'b1) ready_cnt++;
      if (mem_valid === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL mem_txn: unexpected rw=%0b addr=%05h", mem_rw, mem_addr);
        end else if (mem_rw !== exp_q[0].rw || mem_addr !== exp_q[0].addr ||
                     (exp_q[0].rw && mem_wdata !== exp_q[0].data)) begin
          bad++;
          $display("FAIL mem_txn: got rw=%0b addr=%05h wdata=%032h expected rw=%0b addr=%05h wdata=%032h",
                   mem_rw, mem_addr, mem_wdata, exp_q[0].rw, exp_q[0].addr, exp_q[0].data);
        end
        if (!mem_stall && wait_cnt + 1 >= LMEM) begin
          mem_ready = 1'b1;
          wait_cnt  = 0;
          txn_cnt++;
          last_rw   = mem_rw;
          last_addr = mem_addr;
          if (mem_rw) begin
            mem_store[mem_addr] = mem_wdata;
            wr_cnt++;
            lw_addr = mem_addr;
            lw_data = mem_wdata;
          end else begin
            mem_rdata = mem_read(mem_addr);
          end
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
          mem_ready = 1'b0;
          if (!mem_stall) wait_cnt++;
        end
      end else begin
        mem_ready = 1'b0;
        wait_cnt  = 0;
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  // One CPU access: predict traffic/latency/data from the model, run it, compare.
  task automatic cpu_req(input bit rw, input logic [19:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output int lat);
    int idx = int'(a[13:4]);
    int w   = int'(a[3:2]);
    int exp_lat;
    bit stop_ok = 1'b1;
    logic [31:0] exp_rd;
    txn_t t;
    if (m_valid[idx] && m_tag[idx] == a[19:14]) begin
      exp_lat = 1;
    end else begin
      exp_lat = 2 + LMEM;
      if (m_valid[idx] && m_dirty[idx]) begin
        t.rw = 1'b1; t.addr = {m_tag[idx], 10'(idx), 4'h0}; t.data = m_line[idx];
        exp_q.push_back(t);
        exp_lat += LMEM;
      end
      t.rw = 1'b0; t.addr = {a[19:4], 4'h0}; t.data = 128'h0;
      exp_q.push_back(t);
      m_line[idx]  = mem_read({a[19:4], 4'h0});
      m_tag[idx]   = a[19:14];
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
    end
    exp_rd = m_line[idx][w*32 +: 32];
    if (rw) begin
      m_line[idx][w*32 +: 32] = wd;
      m_dirty[idx] = 1'b1;
    end
    @(negedge clk);
    cpu_valid = 1'b1; cpu_rw = rw; cpu_addr = a; cpu_wdata = wd;
    @(negedge clk);
    cpu_valid = 1'b0; cpu_rw = ~rw; cpu_addr = 20'hFFFFF; cpu_wdata = 32'h0;
    lat = 0;
    rd  = 32'h0;
    for (int k = 1; k <= 60; k++) begin
      if (cpu_stopped !== (k >= 2)) stop_ok = 1'b0;
      if (cpu_ready === 1'b1) begin
        lat = k;
        rd  = cpu_rdata;
        break;
      end
      @(negedge clk);
    end
    chk($sformatf("latency@%05h", a), lat, exp_lat);
    chk($sformatf("stopped@%05h", a), stop_ok, 1'b1);
    if (!rw) chk($sformatf("rdata@%05h", a), rd, exp_rd);
    @(negedge clk);
    chk($sformatf("back_idle@%05h", a), {cpu_ready, cpu_stopped}, 2'b00);
  endtask

  // Flush with a simultaneous CPU request that must be ignored.
  task automatic do_flush(output int k_done);
    int d = 0;
    int exp_done;
    int ready0;
    bit stop_ok = 1'b1;
    txn_t t;
    for (int i = 0; i < NL; i++) begin
      if (m_valid[i] && m_dirty[i]) begin
        t.rw = 1'b1; t.addr = {m_tag[i], 10'(i), 4'h0}; t.data = m_line[i];
        exp_q.push_back(t);
        m_dirty[i] = 1'b0;
        d++;
      end
      if (FI != 0) m_valid[i] = 1'b0;
    end
    exp_done = 1 + NL + d * LMEM;
    ready0 = ready_cnt;
    @(negedge clk);
    flush_req = 1'b1; cpu_valid = 1'b1; cpu_rw = 1'b0; cpu_addr = 20'h01230;
    @(negedge clk);
    flush_req = 1'b0; cpu_valid = 1'b0;
    k_done = 0;
    for (int k = 1; k <= 5000; k++) begin
      if (cpu_stopped !== 1'b1) stop_ok = 1'b0;
      if (flush_done === 1'b1) begin
        k_done = k;
        break;
      end
      @(negedge clk);
    end
    chk("flush_latency", k_done, exp_done);
    chk("flush_stopped", stop_ok, 1'b1);
    @(negedge clk);
    chk("flush_done_pulse", {flush_done, cpu_stopped}, 2'b00);
    chk("flush_no_cpu_ready", ready_cnt - ready0, 0);
    chk("flush_all_written", exp_q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    int lat, t0, w0, kf;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {cpu_ready, cpu_stopped, flush_done, mem_valid, mem_rw}, 5'b0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 20'h0);
    chk("rst_mem_wdata", mem_wdata, 128'h0);
    rst = 1'b0;

    // Cold read miss, then hits in the same line
    cpu_req(1'b0, 20'h01230, 32'h0, rd, lat);
    chk("t1_lat", lat, 5);
    chk("t1_data", rd, 32'h5A001230);
    chk("t1_alloc_addr", last_addr, 20'h01230);
    chk("t1_alloc_rw", last_rw, 1'b0);
    t0 = txn_cnt;
    cpu_req(1'b0, 20'h01234, 32'h0, rd, lat);
    chk("t2_lat", lat, 1);
    chk("t2_data", rd, 32'h5A101230);
    chk("t2_no_mem", txn_cnt - t0, 0);

    // Write hit, low byte bits ignored on read, then dirty-victim miss
    cpu_req(1'b1, 20'h01238, 32'hDEADBEEF, rd, lat);
    chk("t3_wr_lat", lat, 1);
    cpu_req(1'b0, 20'h0123A, 32'h0, rd, lat);
    chk("t3_rd_word2", rd, 32'hDEADBEEF);
    w0 = wr_cnt;
    cpu_req(1'b0, 20'h05230, 32'h0, rd, lat);
    chk("t4_lat", lat, 8);
    chk("t4_data", rd, 32'h5A005230);
    chk("t4_wb_count", wr_cnt - w0, 1);
    chk("t4_wb_addr", lw_addr, 20'h01230);
    chk("t4_wb_data", lw_data, 128'h5A301230_DEADBEEF_5A101230_5A001230);

    // Dirty three lines (hit write, write-allocate, last index)
    cpu_req(1'b1, 20'h05230, 32'h12345678, rd, lat);
    cpu_req(1'b1, 20'h00100, 32'hA5A5A5A5, rd, lat);
    chk("t5_wmiss_lat", lat, 5);
    cpu_req(1'b1, 20'h3FFF0, 32'hCAFEF00D, rd, lat);

    // Flush with colliding CPU request
    w0 = wr_cnt;
    do_flush(kf);
    chk("flush_cycles", kf, 1034);
    chk("flush_writes", wr_cnt - w0, 3);
    chk("flush_last_addr", lw_addr, 20'h3FFF0);
    cpu_req(1'b0, 20'h05230, 32'h0, rd, lat);
    chk("post_flush_hit", lat, 1);
    chk("post_flush_data", rd, 32'h12345678);
    cpu_req(1'b0, 20'h01238, 32'h0, rd, lat);
    chk("clean_miss_lat", lat, 5);
    chk("refetch_data", rd, 32'hDEADBEEF);

    // Reset while an allocate is stalled
    @(negedge clk);
    exp_q.push_back({1'b0, 20'h2A5C0, 128'h0});
    mem_stall = 1'b1;
    cpu_valid = 1'b1; cpu_rw = 1'b0; cpu_addr = 20'h2A5C0;
    @(negedge clk);
    cpu_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("stall_mem_valid", {mem_valid, cpu_stopped}, 2'b11);
    chk("stall_mem_addr", mem_addr, 20'h2A5C0);
    rst = 1'b1;
    #1;
    chk("rst_abort", {mem_valid, cpu_stopped, cpu_ready}, 3'b000);
    chk("rst_abort_addr", mem_addr, 20'h0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    mem_stall = 1'b0;
    cpu_req(1'b0, 20'h01230, 32'h0, rd, lat);
    chk("after_rst_miss", lat, 5);
    chk("after_rst_data", rd, 32'h5A001230);
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
